// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Shared sizing helpers and per-stage control record for the
//             pipelined carry-lookahead adder/subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

   // Control part of the per-stage transaction record. Partial sum and the
   // skewed operand bits live beside it, sized per stage.
   typedef struct packed {
      logic valid;
      logic carry;
   } cla_ctl_t;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic int group_count(input int slice_w, input int block);
      return slice_w / block;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla_slice
//  Purpose  : Combinational BLOCK-grouped carry-lookahead adder for one slice.
//  Revision : 1.0  initial release
// ============================================================================
module cla_slice
   import cla_pkg::*;
#(
   parameter int W     = 16,
   parameter int BLOCK = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);
   localparam int NG = group_count(W, BLOCK);

   logic [W-1:0]  w_g;
   logic [W-1:0]  w_p;
   logic [NG-1:0] w_gg;
   logic [NG-1:0] w_gp;
   logic [NG:0]   w_cg;
   logic [W:0]    w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   always_comb begin
      w_gg = '0;
      w_gp = '1;
      for (int j = 0; j < NG; j++) begin
         for (int i = 0; i < BLOCK; i++) begin
            w_gg[j] = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_gg[j]);
            w_gp[j] = w_gp[j] & w_p[j*BLOCK+i];
         end
      end
   end

   // Group-level lookahead: each group carry depends only on group G/P terms.
   always_comb begin
      w_cg[0] = ci;
      for (int j = 0; j < NG; j++) begin
         w_cg[j+1] = w_gg[j] | (w_gp[j] & w_cg[j]);
      end
   end

   always_comb begin
      w_c = '0;
      for (int j = 0; j < NG; j++) begin
         w_c[j*BLOCK] = w_cg[j];
         for (int i = 1; i < BLOCK; i++) begin
            w_c[j*BLOCK+i] = w_g[j*BLOCK+i-1] | (w_p[j*BLOCK+i-1] & w_c[j*BLOCK+i-1]);
         end
      end
      w_c[W] = w_cg[NG];
   end

   assign s     = w_p ^ w_c[W-1:0];
   assign co    = w_c[W];
   assign c_msb = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_addsub
//  Purpose  : Pipelined CLA adder/subtractor with valid/ready handshakes.
//             Define CLA_PIPE_SAT_EN to clamp overflowing sums to signed limits.
//  Revision : 1.0  initial release
// ============================================================================
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int BLOCK  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of
);
   localparam int SW = slice_width(WIDTH, STAGES);
`ifdef CLA_PIPE_SAT_EN
   localparam bit c_sat_en = 1'b1;
`else
   localparam bit c_sat_en = 1'b0;
`endif

   logic w_stall;
   logic w_accept;

   assign w_stall  = out_valid & ~out_ready;
   assign in_ready = ~w_stall;
   assign w_accept = in_valid & in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - k*SW;   // operand bits not yet consumed

      logic [REM-1:0]        w_ua;
      logic [REM-1:0]        w_ub;
      cla_ctl_t              w_ctl;
      logic [SW-1:0]         w_s;
      logic                  w_co;
      logic                  w_cm;
      logic [(k+1)*SW-1:0]   w_sum;
      logic [(k+1)*SW-1:0]   w_next;
      cla_ctl_t              r_ctl;
      logic [(k+1)*SW-1:0]   r_s;

      if (k == 0) begin : g_head
         assign w_ua  = a;
         assign w_ub  = b ^ {WIDTH{sub}};
         assign w_ctl = '{valid: w_accept, carry: cin ^ sub};
         assign w_sum = w_s;
      end else begin : g_tail
         assign w_ua  = g_stage[k-1].g_skew.r_ua;
         assign w_ub  = g_stage[k-1].g_skew.r_ub;
         assign w_ctl = g_stage[k-1].r_ctl;
         assign w_sum = {w_s, g_stage[k-1].r_s};
      end

      cla_slice #(.W(SW), .BLOCK(BLOCK)) u_slice (
         .a     (w_ua[SW-1:0]),
         .b     (w_ub[SW-1:0]),
         .ci    (w_ctl.carry),
         .s     (w_s),
         .co    (w_co),
         .c_msb (w_cm)
      );

      if (k == STAGES-1) begin : g_out
         logic             w_of;
         logic [WIDTH-1:0] w_res;
         logic             r_of;

         assign w_of = w_cm ^ w_co;

         // Clamp direction follows the sign of operand A (its MSB is still in w_ua).
         always_comb begin
            w_res = w_sum;
            if (c_sat_en && w_of) begin
               w_res = {w_ua[REM-1], {(WIDTH-1){~w_ua[REM-1]}}};
            end
         end
         assign w_next = w_res;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_of <= 1'b0;
            end else if (!w_stall && w_ctl.valid) begin
               r_of <= w_of;
            end
         end
      end else begin : g_skew
         logic [REM-SW-1:0] r_ua;
         logic [REM-SW-1:0] r_ub;

         assign w_next = w_sum;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ua <= '0;
               r_ub <= '0;
            end else if (!w_stall && w_ctl.valid) begin
               r_ua <= w_ua[REM-1:SW];
               r_ub <= w_ub[REM-1:SW];
            end
         end
      end

      // Bubbles advance; data fields only update on a valid transaction.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_ctl <= '0;
            r_s   <= '0;
         end else if (!w_stall) begin
            r_ctl.valid <= w_ctl.valid;
            if (w_ctl.valid) begin
               r_ctl.carry <= w_co;
               r_s         <= w_next;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_ctl.valid;
   assign cout      = g_stage[STAGES-1].r_ctl.carry;
   assign sum       = g_stage[STAGES-1].r_s;
   assign of        = g_stage[STAGES-1].g_out.r_of;

endmodule
`default_nettype wire
